// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one UART transmitter between two byte-stream requesters. A requester
// keeps the transmitter for a whole packet (terminated by its `last` flag);
// ownership rotates round-robin at packet boundaries, and a grant is revoked
// when the owner leaves `valid` low mid-packet for TIMEOUT SEND cycles.
//
// Build option:
//   UART_ARB_FIXED_PRIO_EN  when defined, req0 always wins arbitration in IDLE
//                           and the round-robin pointer is removed. Timeout
//                           behaviour is identical in both builds.
//
// Parameters:
//   TIMEOUT          stalled SEND cycles before revocation, 1..255
//
// Ports:
//   clock            sole clock, posedge
//   reset            synchronous, active-high
//   reqN_valid       requester N has a byte pending
//   reqN_byte[7:0]   pending byte, stable until reqN_ready is seen
//   reqN_last        pending byte ends the packet
//   reqN_ready       one-cycle pulse, byte accepted
//   is_transmitting  UART busy flag
//   transmit         one-cycle start pulse to the UART
//   tx_byte[7:0]     byte to the UART, holds its value between pulses
//   grant[1:0]       one-hot owner, 00 when idle
//   timeout          one-cycle pulse when a grant is revoked
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no owner; arbitrate among asserted valids
// SEND   | owner holds grant; issue its byte once the UART is idle
// WAIT   | byte issued; skip one cycle for the UART busy flag, then wait
//        | for it to clear and either return to SEND or release the grant

module uart_tx_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_byte,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_byte,
   input  logic       req1_last,
   output logic       req1_ready,
   input  logic       is_transmitting,
   output logic       transmit,
   output logic [7:0] tx_byte,
   output logic [1:0] grant,
   output logic       timeout
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t     state_q;
   logic       wait_first_q;
   logic       last_q;
   logic [7:0] cnt_q;
   logic       transmit_q;
   logic [7:0] tx_byte_q;
   logic       ready0_q;
   logic       ready1_q;
   logic [1:0] grant_q;
   logic       timeout_q;
`ifndef UART_ARB_FIXED_PRIO_EN
   // 0: req0 preferred on a tie, 1: req1 preferred
   logic       ptr_q;
`endif

   logic       own_valid;
   logic [7:0] own_byte;
   logic       own_last;
   logic [7:0] cnt_d;
   logic [1:0] grant_d;

   // Owner-side mux; only meaningful while grant_q is non-zero.
   always_comb begin
      own_valid = 1'b0;
      own_byte  = 8'h00;
      own_last  = 1'b0;
      if (grant_q[1]) begin
         own_valid = req1_valid;
         own_byte  = req1_byte;
         own_last  = req1_last;
      end else begin
         own_valid = req0_valid;
         own_byte  = req0_byte;
         own_last  = req0_last;
      end
   end

   // Saturating increment: the counter must never wrap back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != 8'hFF) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Arbitration result for the IDLE state.
   always_comb begin
      grant_d = 2'b00;
`ifdef UART_ARB_FIXED_PRIO_EN
      if (req0_valid) begin
         grant_d = 2'b01;
      end else if (req1_valid) begin
         grant_d = 2'b10;
      end
`else
      if (req0_valid && req1_valid) begin
         grant_d = ptr_q ? 2'b10 : 2'b01;
      end else if (req0_valid) begin
         grant_d = 2'b01;
      end else if (req1_valid) begin
         grant_d = 2'b10;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wait_first_q <= 1'b0;
         last_q       <= 1'b0;
         cnt_q        <= 8'h00;
         transmit_q   <= 1'b0;
         tx_byte_q    <= 8'h00;
         ready0_q     <= 1'b0;
         ready1_q     <= 1'b0;
         grant_q      <= 2'b00;
         timeout_q    <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
         ptr_q        <= 1'b0;
`endif
      end else begin
         // Pulsed outputs default low; tx_byte_q is deliberately not cleared.
         transmit_q <= 1'b0;
         ready0_q   <= 1'b0;
         ready1_q   <= 1'b0;
         timeout_q  <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (grant_d != 2'b00) begin
                  grant_q <= grant_d;
                  cnt_q   <= 8'h00;
                  state_q <= S_SEND;
               end
            end

            S_SEND: begin
               if (own_valid) begin
                  // Owner ready but UART busy: hold without advancing the counter.
                  if (!is_transmitting) begin
                     transmit_q   <= 1'b1;
                     tx_byte_q    <= own_byte;
                     ready0_q     <= grant_q[0];
                     ready1_q     <= grant_q[1];
                     last_q       <= own_last;
                     cnt_q        <= 8'h00;
                     wait_first_q <= 1'b1;
                     state_q      <= S_WAIT;
                  end
               end else if (cnt_d >= TIMEOUT_C) begin
                  timeout_q <= 1'b1;
                  grant_q   <= 2'b00;
                  cnt_q     <= 8'h00;
`ifndef UART_ARB_FIXED_PRIO_EN
                  ptr_q     <= grant_q[0];
`endif
                  state_q   <= S_IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            S_WAIT: begin
               // The UART only raises its busy flag one cycle after the start
               // pulse, so the first WAIT cycle must not trust is_transmitting.
               if (wait_first_q) begin
                  wait_first_q <= 1'b0;
               end else if (!is_transmitting) begin
                  if (last_q) begin
                     grant_q <= 2'b00;
`ifndef UART_ARB_FIXED_PRIO_EN
                     ptr_q   <= grant_q[0];
`endif
                     state_q <= S_IDLE;
                  end else begin
                     state_q <= S_SEND;
                  end
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign transmit   = transmit_q;
   assign tx_byte    = tx_byte_q;
   assign req0_ready = ready0_q;
   assign req1_ready = ready1_q;
   assign grant      = grant_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (TIMEOUT = 8) with a small UART model
// and a transmit log of {grant, tx_byte} captured on every start pulse.

module tb_uart_tx_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_byte = 8'h00;
   logic       req0_last = 1'b0;
   logic       req0_ready;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_byte = 8'h00;
   logic       req1_last = 1'b0;
   logic       req1_ready;
   logic       is_transmitting;
   logic       transmit;
   logic [7:0] tx_byte;
   logic [1:0] grant;
   logic       timeout;

   int n_cmp = 0;
   int n_mis = 0;

   uart_tx_arbiter #(.TIMEOUT(8)) dut (
      .clock          (clock),
      .reset          (reset),
      .req0_valid     (req0_valid),
      .req0_byte      (req0_byte),
      .req0_last      (req0_last),
      .req0_ready     (req0_ready),
      .req1_valid     (req1_valid),
      .req1_byte      (req1_byte),
      .req1_last      (req1_last),
      .req1_ready     (req1_ready),
      .is_transmitting(is_transmitting),
      .transmit       (transmit),
      .tx_byte        (tx_byte),
      .grant          (grant),
      .timeout        (timeout)
   );

   always #5 clock = ~clock;

   // UART model: busy for busy_len cycles starting the edge after transmit.
   int   busy_len = 3;
   int   busy_cnt = 0;
   logic busy_force = 1'b0;
   always @(posedge clock) begin
      if (transmit) busy_cnt <= busy_len;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign is_transmitting = (busy_cnt != 0) || busy_force;

   logic [9:0] log_q[$];
   int n_overlap = 0;
   int n_rdy_err = 0;
   always @(negedge clock) begin
      if (transmit) begin
         log_q.push_back({grant, tx_byte});
         if (is_transmitting) n_overlap++;
      end
      if (transmit != (req0_ready | req1_ready)) n_rdy_err++;
      if ((req0_ready && grant != 2'b01) || (req1_ready && grant != 2'b10)) n_rdy_err++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int r, input logic v, input logic [7:0] b, input logic l);
      if (r == 0) begin
         req0_valid = v; req0_byte = b; req0_last = l;
      end else begin
         req1_valid = v; req1_byte = b; req1_last = l;
      end
   endtask

   task automatic wait_ready(input int r, input string tag);
      int   w;
      logic rdy;
      w = 0;
      rdy = 1'b0;
      while (!rdy && w < 300) begin
         @(negedge clock);
         w++;
         rdy = (r == 0) ? req0_ready : req1_ready;
      end
      if (!rdy) chk(tag, {31'd0, rdy}, 32'd1);
   endtask

   task automatic drive(input int r, input logic [31:0] bytes, input int n);
      for (int i = 0; i < n; i++) begin
         set_req(r, 1'b1, bytes[8*i +: 8], (i == n - 1));
         wait_ready(r, "drv_ready");
      end
      set_req(r, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      busy_force = 1'b0;
      set_req(0, 1'b0, 8'h00, 1'b0);
      set_req(1, 1'b0, 8'h00, 1'b0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (15) @(negedge clock);
      log_q.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_to, n_tx, n_cnt;

      // Reset values
      repeat (3) @(negedge clock);
      chk("rst_transmit", {31'd0, transmit}, 32'd0);
      chk("rst_tx_byte", {24'd0, tx_byte}, 32'h00);
      chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("rst_grant", {30'd0, grant}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Single requester, 3 bytes, UART busy 10 cycles per byte
      busy_len = 10;
      log_q.delete();
      set_req(0, 1'b1, 8'h42, 1'b0);
      @(negedge clock);
      chk("t1_grant_lat", {30'd0, grant}, 32'h1);
      chk("t1_tx_early", {31'd0, transmit}, 32'd0);
      @(negedge clock);
      chk("t1_tx_lat", {31'd0, transmit}, 32'd1);
      chk("t1_ready_lat", {31'd0, req0_ready}, 32'd1);
      chk("t1_byte0", {24'd0, tx_byte}, 32'h42);
      @(negedge clock);
      chk("t1_tx_pulse", {30'd0, transmit, req0_ready}, 32'd0);
      chk("t1_byte_hold", {24'd0, tx_byte}, 32'h42);
      drive(0, 32'h0000_4443, 2);
      repeat (15) @(negedge clock);
      chk("t1_grant_end", {30'd0, grant}, 32'd0);
      chk("t1_log_size", log_q.size(), 32'd3);
      chk("t1_log0", {22'd0, log_q[0]}, {22'd0, 2'b01, 8'h42});
      chk("t1_log1", {22'd0, log_q[1]}, {22'd0, 2'b01, 8'h43});
      chk("t1_log2", {22'd0, log_q[2]}, {22'd0, 2'b01, 8'h44});

      // Contention right after reset: req0 packet first, no interleave
      busy_len = 3;
      do_reset();
      fork
         drive(0, 32'h0000_0ECD, 2);
         drive(1, 32'h0000_0A10, 2);
      join
      repeat (10) @(negedge clock);
      chk("t2_log_size", log_q.size(), 32'd4);
      chk("t2_log0", {22'd0, log_q[0]}, {22'd0, 2'b01, 8'hCD});
      chk("t2_log1", {22'd0, log_q[1]}, {22'd0, 2'b01, 8'h0E});
      chk("t2_log2", {22'd0, log_q[2]}, {22'd0, 2'b10, 8'h10});
      chk("t2_log3", {22'd0, log_q[3]}, {22'd0, 2'b10, 8'h0A});

      // Fairness: both continuously valid, single-byte packets
      busy_len = 2;
      do_reset();
      fork
         for (int i = 0; i < 4; i++) drive(0, 32'hA0 + i, 1);
         for (int j = 0; j < 4; j++) drive(1, 32'hB0 + j, 1);
      join
      repeat (10) @(negedge clock);
      chk("t3_log_size", log_q.size(), 32'd8);
`ifdef UART_ARB_FIXED_PRIO_EN
      chk("t3_pkt0", {22'd0, log_q[0]}, {22'd0, 2'b01, 8'hA0});
      chk("t3_pkt1", {22'd0, log_q[1]}, {22'd0, 2'b01, 8'hA1});
      chk("t3_pkt2", {22'd0, log_q[2]}, {22'd0, 2'b01, 8'hA2});
      chk("t3_pkt3", {22'd0, log_q[3]}, {22'd0, 2'b01, 8'hA3});
`else
      chk("t3_pkt0", {22'd0, log_q[0]}, {22'd0, 2'b01, 8'hA0});
      chk("t3_pkt1", {22'd0, log_q[1]}, {22'd0, 2'b10, 8'hB0});
      chk("t3_pkt2", {22'd0, log_q[2]}, {22'd0, 2'b01, 8'hA1});
      chk("t3_pkt3", {22'd0, log_q[3]}, {22'd0, 2'b10, 8'hB1});
`endif

      // Stall timeout (TIMEOUT = 8), UART never busy
      busy_len = 0;
      do_reset();
      set_req(1, 1'b1, 8'h55, 1'b0);
      @(negedge clock);
      chk("t4_grant1", {30'd0, grant}, 32'h2);
      set_req(0, 1'b1, 8'h77, 1'b1);
      @(negedge clock);
      chk("t4_tx1", {31'd0, transmit}, 32'd1);
      chk("t4_byte1", {24'd0, tx_byte}, 32'h55);
      chk("t4_ready1", {31'd0, req1_ready}, 32'd1);
      set_req(1, 1'b0, 8'h00, 1'b0);
      n_to = 0;
      repeat (9) begin
         @(negedge clock);
         n_to += int'(timeout);
      end
      chk("t4_no_early_timeout", n_to, 32'd0);
      @(negedge clock);
      chk("t4_timeout", {31'd0, timeout}, 32'd1);
      chk("t4_grant_revoked", {30'd0, grant}, 32'd0);
      @(negedge clock);
      chk("t4_timeout_pulse", {31'd0, timeout}, 32'd0);
      chk("t4_grant0", {30'd0, grant}, 32'h1);
      @(negedge clock);
      chk("t4_tx0", {31'd0, transmit}, 32'd1);
      chk("t4_byte0", {24'd0, tx_byte}, 32'h77);
      chk("t4_ready0", {31'd0, req0_ready}, 32'd1);
      set_req(0, 1'b0, 8'h00, 1'b0);

      // UART busy hold for 20 cycles
      busy_len = 3;
      do_reset();
      busy_force = 1'b1;
      set_req(0, 1'b1, 8'h5A, 1'b1);
      n_tx = 0; n_to = 0; n_cnt = 0;
      repeat (20) begin
         @(negedge clock);
         n_tx += int'(transmit);
         n_to += int'(timeout);
         if (dut.cnt_q != 8'h00) n_cnt++;
      end
      chk("t5_no_tx", n_tx, 32'd0);
      chk("t5_no_timeout", n_to, 32'd0);
      chk("t5_cnt_zero", n_cnt, 32'd0);
      chk("t5_grant", {30'd0, grant}, 32'h1);
      busy_force = 1'b0;
      @(negedge clock);
      chk("t5_tx", {31'd0, transmit}, 32'd1);
      chk("t5_byte", {24'd0, tx_byte}, 32'h5A);
      set_req(0, 1'b0, 8'h00, 1'b0);

      // Reset during WAIT of byte 2 of 3, then a clean packet
      busy_len = 4;
      do_reset();
      set_req(0, 1'b1, 8'h11, 1'b0);
      wait_ready(0, "t6_ready_b0");
      set_req(0, 1'b1, 8'h22, 1'b0);
      wait_ready(0, "t6_ready_b1");
      reset = 1'b1;
      set_req(0, 1'b0, 8'h00, 1'b0);
      @(negedge clock);
      chk("t6_transmit", {31'd0, transmit}, 32'd0);
      chk("t6_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("t6_grant", {30'd0, grant}, 32'd0);
      chk("t6_timeout", {31'd0, timeout}, 32'd0);
      chk("t6_tx_byte", {24'd0, tx_byte}, 32'h00);
      chk("t6_state", {30'd0, dut.state_q}, 32'd0);
      reset = 1'b0;
      drive(0, 32'h0000_00E1, 1);
      repeat (10) @(negedge clock);
      chk("t6_log_size", log_q.size(), 32'd3);
      chk("t6_log2", {22'd0, log_q[2]}, {22'd0, 2'b01, 8'hE1});
      chk("t6_grant_end", {30'd0, grant}, 32'd0);

      // Invariants collected by the monitor across the whole run
      chk("overlap", n_overlap, 32'd0);
      chk("ready_vs_transmit", n_rdy_err, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between two byte-stream requesters, for example the host command controller's read responses and a debug/status stream. Each requester owns the transmitter for a whole packet, delimited by a `last` flag. Ownership passes round-robin at packet boundaries and is revoked if an owner stalls mid-packet. The block sits between the requesters and the UART TX port pair `transmit` / `tx_byte` / `is_transmitting`.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles an owner may hold the grant with `valid` low mid-packet before it is revoked; legal range 1..255 (8-bit counter).

Ports:
- `clock`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester has a byte pending.
- `req0_byte` / `req1_byte`  in  8  pending byte; held stable while `valid` is high and `ready` has not yet been seen.
- `req0_last` / `req1_last`  in  1  pending byte ends the packet.
- `req0_ready` / `req1_ready`  out  1  one-cycle pulse: byte accepted.
- `is_transmitting`  in  1  UART busy.
- `transmit`  out  1  one-cycle start pulse to the UART.
- `tx_byte`  out  8  byte to the UART; valid while `transmit` is high.
- `grant`  out  2  one-hot current owner; 00 when idle.
- `timeout`  out  1  one-cycle pulse when a grant is revoked.

## Operation
- States: IDLE, SEND, WAIT.
- IDLE:
  - No `valid` asserted: remain in IDLE.
  - Exactly one `valid`: grant that requester.
  - Both `valid`: grant the requester named by the priority pointer `ptr`.
  - On any grant, set `grant` and go to SEND.
- SEND, owner `valid`=1 and `is_transmitting`=0:
  - Register `transmit`=1, `tx_byte`=owner byte, owner `ready`=1.
  - Latch owner `last`, clear the timeout counter, go to WAIT.
- SEND, owner `valid`=0:
  - Increment the timeout counter.
  - When the counter reaches `TIMEOUT`: pulse `timeout`, clear `grant`, set `ptr` to the other requester, go to IDLE.
- SEND, owner `valid`=1 and `is_transmitting`=1: hold; the counter does not advance.
- WAIT:
  - On the first WAIT cycle, deassert `transmit` and `ready` and ignore `is_transmitting`. The UART registers its busy flag that cycle.
  - From the second WAIT cycle, once `is_transmitting`=0:
    - If latched `last`=1: clear `grant`, set `ptr` to the other requester, go to IDLE.
    - Otherwise go to SEND.
- The non-owner's `valid` is ignored until the block returns to IDLE. Its `ready` stays 0.
- `tx_byte` holds its last value when `transmit` is 0.

## Timing
- Reset values: state IDLE, `ptr`=0 (req0 preferred), `transmit`=0, `tx_byte`=00, both `ready`=0, `grant`=00, `timeout`=0, counter 0.
- Every output is registered.
- Latency from `valid` rising in IDLE at edge N:
  - `grant` high after edge N.
  - `transmit` and `ready` high after edge N+1, provided the UART is idle.
- `transmit` and `ready` rise on the same edge and last exactly one cycle. The requester changes its byte or `valid` only after it sees `ready`.
- Back-to-back bytes within a packet are at least 3 cycles apart, plus the UART busy time.
- A packet boundary with the other requester waiting adds one IDLE cycle.
- Simultaneous `valid` in IDLE: `ptr` decides. `ptr` toggles only on packet end or timeout.
- A single-byte packet (`last`=1 on the first byte) is legal.
- Reset mid-operation:
  - Outputs drop immediately; any in-flight UART byte is not aborted.
  - SEND's `is_transmitting` check prevents overlap after reset.
- `TIMEOUT` counter is 8 bits and saturates; it never wraps.

## Configuration
- `UART_ARB_FIXED_PRIO_EN` defined:
  - In IDLE, req0 wins whenever its `valid` is high.
  - `ptr` is unused and `grant` never rotates by policy.
  - The timeout behaviour is unchanged.
- Not defined: round-robin as described above.

## Test plan
- Single requester: req0 sends 3 bytes 0x42 0x43 0x44, `last` on 0x44, with UART busy for 10 cycles per byte. Required: three `transmit` pulses with `tx_byte` 42, 43, 44 in order; `grant`=01 throughout, then 00.
- Contention: both requesters present 2-byte packets in the same cycle after reset. Required: req0's packet (0xCD, 0x0E) is sent fully, then req1's (0x10, 0x0A); no interleaving.
- Fairness: both requesters continuously valid for 4 packets. Required: grant order 01, 10, 01, 10. With `UART_ARB_FIXED_PRIO_EN` defined: 01, 01, 01, 01.
- Stall timeout: `TIMEOUT`=8; req1 sends one non-last byte, then drops `valid`, while req0 waits. Required:
  - `timeout` pulses exactly 8 stalled SEND cycles later.
  - req0 is granted on the next cycle.
  - Its first byte is sent once `is_transmitting` falls.
- UART busy hold: `is_transmitting` held at 1 for 20 cycles with req0 valid. Required: no `transmit` until the cycle after `is_transmitting` falls; counter and `timeout` stay 0.
- Reset mid-packet: assert `reset` during WAIT of byte 2 of 3. Required: all outputs 0 on the next cycle, state IDLE; a new packet is sent cleanly afterwards.
